seq_popcount_neuron: RTL and testbench



---
 rtl/popcount_pkg.sv | 19 +
 rtl/seq_popcount_neuron_if.sv | 31 +++
 rtl/popcount_exact.sv | 20 ++
 rtl/seq_popcount_neuron.sv | 101 ++++++++++
 tb/tb_seq_popcount_neuron.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the sequential popcount neuron.
package popcount_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    // Bits needed to hold a popcount of n_in inputs.
    function automatic int unsigned cnt_w(input int unsigned n_in);
        return $clog2(n_in + 1);
    endfunction

    // Signed accumulator width covering +/- n_in*n_beats.
    function automatic int unsigned acc_w(input int unsigned n_in, input int unsigned n_beats);
        return $clog2(n_in * n_beats + 1) + 1;
    endfunction

endpackage

// File: rtl/seq_popcount_neuron_if.sv
// Beat input / result output bundle for the sequential popcount neuron.
interface seq_popcount_neuron_if #(
    parameter int unsigned N_IN    = 24,
    parameter int unsigned N_BEATS = 4
);
    import popcount_pkg::*;

    localparam int unsigned ACC_W = acc_w(N_IN, N_BEATS);

    logic                    clr;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN-1:0]         in_pos;
    logic [N_IN-1:0]         in_neg;
    logic signed [ACC_W-1:0] thr;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_bit;

    modport master (
        output clr, in_valid, in_pos, in_neg, thr, out_ready,
        input  in_ready, out_valid, out_sum, out_bit
    );

    modport slave (
        input  clr, in_valid, in_pos, in_neg, thr, out_ready,
        output in_ready, out_valid, out_sum, out_bit
    );

endinterface

// File: rtl/popcount_exact.sv
// Combinational exact population count of a W-bit vector.
module popcount_exact
    import popcount_pkg::*;
#(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0]          vec,
    output logic [cnt_w(W)-1:0]   count_c
);

    localparam int unsigned CNT_W = cnt_w(W);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            count_c = count_c + CNT_W'(vec[i]);
        end
    end

endmodule

// File: rtl/seq_popcount_neuron.sv
// Binary-weight neuron: accumulates (+1/-1) popcount deltas over N_BEATS beats and fires against thr.
module seq_popcount_neuron
    import popcount_pkg::*;
#(
    parameter int unsigned N_IN        = 24,
    parameter int unsigned N_BEATS     = 4,
    parameter int unsigned APPROX_DROP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_popcount_neuron_if.slave  bus
);

    localparam int unsigned CNT_W  = cnt_w(N_IN);
    localparam int unsigned ACC_W  = acc_w(N_IN, N_BEATS);
    localparam int unsigned BEAT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    // Low APPROX_DROP input bits are ignored in both masks.
    localparam logic [N_IN-1:0] KEEP_MASK = {N_IN{1'b1}} << APPROX_DROP;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [BEAT_W-1:0]       beat_cnt;

    logic [N_IN-1:0]         pos_m_c;
    logic [N_IN-1:0]         neg_m_c;
    logic [CNT_W-1:0]        pos_cnt_c;
    logic [CNT_W-1:0]        neg_cnt_c;
    logic signed [ACC_W-1:0] delta_c;
    logic signed [ACC_W-1:0] sum_next_c;
    logic                    last_beat_c;

    assign pos_m_c = bus.in_pos & KEEP_MASK;
    assign neg_m_c = bus.in_neg & KEEP_MASK;

    popcount_exact #(.W(N_IN)) u_pos_cnt (
        .vec     (pos_m_c),
        .count_c (pos_cnt_c)
    );

    popcount_exact #(.W(N_IN)) u_neg_cnt (
        .vec     (neg_m_c),
        .count_c (neg_cnt_c)
    );

    // Bits set in both masks cancel naturally through the subtraction.
    assign delta_c     = $signed(ACC_W'(pos_cnt_c)) - $signed(ACC_W'(neg_cnt_c));
    assign sum_next_c  = acc + delta_c;
    assign last_beat_c = (beat_cnt == BEAT_W'(N_BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_ACCUM;
            acc           <= '0;
            beat_cnt      <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_bit   <= 1'b0;
        end else if (bus.clr) begin
            state         <= ST_ACCUM;
            acc           <= '0;
            beat_cnt      <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (bus.in_valid && bus.in_ready) begin
                        if (last_beat_c) begin
                            state         <= ST_OUT;
                            acc           <= '0;
                            beat_cnt      <= '0;
                            bus.in_ready  <= 1'b0;
                            bus.out_valid <= 1'b1;
                            bus.out_sum   <= sum_next_c;
                            bus.out_bit   <= (sum_next_c >= bus.thr);
                        end else begin
                            acc      <= sum_next_c;
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    // Result held until consumed; no beat taken in the handshake cycle.
                    if (bus.out_ready) begin
                        state         <= ST_ACCUM;
                        bus.in_ready  <= 1'b1;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_ACCUM;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_popcount_neuron.sv
// Directed self-checking bench: default neuron plus an APPROX_DROP=8 instance.
module tb_seq_popcount_neuron;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    localparam logic [23:0] ONES = 24'hFFFFFF;

    seq_popcount_neuron_if #(.N_IN(24), .N_BEATS(4)) a_if ();
    seq_popcount_neuron_if #(.N_IN(24), .N_BEATS(4)) b_if ();

    seq_popcount_neuron #(.N_IN(24), .N_BEATS(4), .APPROX_DROP(0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    seq_popcount_neuron #(.N_IN(24), .N_BEATS(4), .APPROX_DROP(8)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int o_sum(input bit sel);
        return sel ? int'(b_if.out_sum) : int'(a_if.out_sum);
    endfunction

    function automatic int o_bit(input bit sel);
        return sel ? int'(b_if.out_bit) : int'(a_if.out_bit);
    endfunction

    function automatic int o_valid(input bit sel);
        return sel ? int'(b_if.out_valid) : int'(a_if.out_valid);
    endfunction

    function automatic int i_ready(input bit sel);
        return sel ? int'(b_if.in_ready) : int'(a_if.in_ready);
    endfunction

    // Offer one beat, waiting a bounded number of cycles for acceptance; returns 1 cycle after accept.
    task automatic beat(input bit sel, input logic [23:0] pos, input logic [23:0] neg, input logic signed [7:0] t);
        bit accepted;
        accepted = 1'b0;
        if (sel) begin
            b_if.in_pos = pos; b_if.in_neg = neg; b_if.thr = t; b_if.in_valid = 1'b1;
        end else begin
            a_if.in_pos = pos; a_if.in_neg = neg; a_if.thr = t; a_if.in_valid = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            if (i_ready(sel) == 1) begin
                @(posedge clk); #1;
                accepted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        check("beat_accept", int'(accepted), 1);
    endtask

    task automatic run4(input bit sel, input logic [23:0] pos, input logic [23:0] neg, input logic signed [7:0] t);
        for (int i = 0; i < 4; i++) beat(sel, pos, neg, t);
    endtask

    // Consume result; a beat is offered in the same cycle and must be ignored.
    task automatic consume(input bit sel);
        if (sel) begin
            b_if.out_ready = 1'b1; b_if.in_valid = 1'b1; b_if.in_pos = ONES; b_if.in_neg = '0;
        end else begin
            a_if.out_ready = 1'b1; a_if.in_valid = 1'b1; a_if.in_pos = ONES; a_if.in_neg = '0;
        end
        @(posedge clk); #1;
        a_if.out_ready = 1'b0; a_if.in_valid = 1'b0;
        b_if.out_ready = 1'b0; b_if.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        a_if.clr = 1'b0; a_if.in_valid = 1'b0; a_if.in_pos = '0; a_if.in_neg = '0; a_if.thr = '0; a_if.out_ready = 1'b0;
        b_if.clr = 1'b0; b_if.in_valid = 1'b0; b_if.in_pos = '0; b_if.in_neg = '0; b_if.thr = '0; b_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", i_ready(0), 1);
        check("rst_out_valid", o_valid(0), 0);
        check("rst_out_sum", o_sum(0), 0);
        check("rst_out_bit", o_bit(0), 0);

        // All positive: 24*4 = 96, fires at thr 0, out_valid one cycle after 4th beat
        for (int i = 0; i < 3; i++) beat(0, ONES, '0, 8'sd0);
        check("pos_no_early_valid", o_valid(0), 0);
        beat(0, ONES, '0, 8'sd0);
        check("pos_latency_valid", o_valid(0), 1);
        check("pos_sum", o_sum(0), 96);
        check("pos_bit", o_bit(0), 1);
        check("pos_in_ready_low", i_ready(0), 0);
        consume(0);
        check("hs_out_valid_low", o_valid(0), 0);
        check("hs_in_ready_high", i_ready(0), 1);

        // Beat offered during handshake must not count: 4 x 1 = 4
        run4(0, 24'h000001, '0, 8'sd0);
        check("hs_no_extra_beat", o_sum(0), 4);
        consume(0);

        // All negative
        run4(0, '0, ONES, 8'sd0);
        check("neg_sum", o_sum(0), -96);
        check("neg_bit", o_bit(0), 0);
        consume(0);

        // Both masks set cancel
        run4(0, ONES, ONES, 8'sd0);
        check("cancel_sum", o_sum(0), 0);
        check("cancel_bit", o_bit(0), 1);
        consume(0);

        // Threshold equality with idle gaps; thr sampled only on last beat
        for (int i = 0; i < 3; i++) begin
            beat(0, 24'h000003, '0, 8'sd100);
            repeat (3) @(posedge clk);
            #1;
        end
        beat(0, 24'h000003, '0, 8'sd8);
        check("thr_eq_sum", o_sum(0), 8);
        check("thr_eq_bit", o_bit(0), 1);
        consume(0);
        run4(0, 24'h000003, '0, 8'sd9);
        check("thr_above_bit", o_bit(0), 0);
        consume(0);

        // APPROX_DROP=8 instance
        run4(1, ONES, '0, 8'sd0);
        check("drop_ones_sum", o_sum(1), 64);
        consume(1);
        run4(1, 24'h0000FF, '0, 8'sd0);
        check("drop_low_sum", o_sum(1), 0);
        consume(1);

        // Output stall for 5 cycles holds the result
        run4(0, 24'h00000F, '0, 8'sd0);
        check("stall_sum_start", o_sum(0), 16);
        a_if.in_valid = 1'b1; a_if.in_pos = ONES;
        repeat (5) @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
        check("stall_out_valid", o_valid(0), 1);
        check("stall_in_ready", i_ready(0), 0);
        check("stall_sum_held", o_sum(0), 16);
        consume(0);
        check("stall_release_ready", i_ready(0), 1);

        // clr after 2 beats, with a beat offered in the clr cycle
        beat(0, ONES, '0, 8'sd0);
        beat(0, ONES, '0, 8'sd0);
        a_if.clr = 1'b1; a_if.in_valid = 1'b1; a_if.in_pos = ONES;
        @(posedge clk); #1;
        a_if.clr = 1'b0; a_if.in_valid = 1'b0;
        run4(0, 24'h000001, '0, 8'sd0);
        check("clr_sum", o_sum(0), 4);

        // clr while holding a result drops out_valid
        a_if.clr = 1'b1;
        @(posedge clk); #1;
        a_if.clr = 1'b0;
        check("clr_out_valid", o_valid(0), 0);
        check("clr_in_ready", i_ready(0), 1);

        // Async reset in OUT clears outputs without a clock edge
        run4(0, ONES, '0, 8'sd0);
        check("pre_rst_valid", o_valid(0), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_valid", o_valid(0), 0);
        check("async_rst_sum", o_sum(0), 0);
        check("async_rst_bit", o_bit(0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_ready", i_ready(0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
